// File: rtl/block_cache_pkg.sv
// ---------------------------------------------------------------------------
// block_cache_pkg
// Shared types for the block cache and its neighbours.
//   BlockPos        : block address as seen by the cache and by L3
//   BlockType       : one cached block of data
//   miss_state_t    : miss-handling FSM states
//   sat_add32()     : 32-bit saturating add used by the optional statistics
// ---------------------------------------------------------------------------
package block_cache_pkg;

    localparam int BLOCK_POS_W  = 8;
    localparam int BLOCK_TYPE_W = 32;

    typedef logic [BLOCK_POS_W-1:0]  BlockPos;
    typedef logic [BLOCK_TYPE_W-1:0] BlockType;

    typedef enum logic {
        MISS_IDLE  = 1'b0,
        MISS_FETCH = 1'b1
    } miss_state_t;

    // Adds b to a and pins the result at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/block_cache_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter: grants the first requester found after the port that
// was served last, wrapping around. The "last served" marker only moves when
// the caller pulses i_advance, so a grant can be looked at for free and only
// consumed when the caller actually acts on it.
// Ports:
//   clk_in    : clock, rising edge
//   rst_in    : asynchronous active-low reset (port 0 gets first priority)
//   i_req     : request vector, one bit per requester
//   i_advance : consume the current grant (update the last-served marker)
//   o_grant   : one-hot grant, zero when nothing requests
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [N-1:0] i_req,
    input  logic         i_advance,
    output logic [N-1:0] o_grant
);

    localparam logic [N-1:0] ONE       = N'(1);
    // Pretending the top requester was served last makes port 0 win first.
    localparam logic [N-1:0] LAST_INIT = ONE << (N - 1);

    logic [N-1:0] r_last_oh;
    logic [N-1:0] w_after;
    logic [N-1:0] w_hi;
    logic [N-1:0] w_pick;

    // Bits strictly above the last-served one: ~(last | (last - 1)).
    assign w_after = ~(r_last_oh | (r_last_oh - ONE));
    assign w_hi    = i_req & w_after;
    // Nobody above the marker requests -> wrap and take the lowest requester.
    assign w_pick  = (|w_hi) ? w_hi : i_req;
    // Isolate the lowest set bit.
    assign o_grant = w_pick & (~w_pick + ONE);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_last_oh <= LAST_INIT;
        end else if (i_advance && (|o_grant)) begin
            r_last_oh <= o_grant;
        end
    end

endmodule

// File: rtl/block_cache.sv
// ---------------------------------------------------------------------------
// block_cache
// Multi-port, fully-associative block cache with a single outstanding miss
// fetch to L3 and write-through of every block update.
//
// Optional feature: define BLOCK_CACHE_STATS_EN to add the saturating
// hit_count / miss_count outputs. Without it those ports do not exist.
//
// Ports:
//   clk_in, rst_in               : clock (rising) / async active-low reset
//   addr[PORTS], read_enable     : per-port lookup request
//   out[PORTS], valid            : registered hit data / hit flag
//   wr_enable, wr_addr, wr_data  : block update (updates only if present)
//   l3_addr, l3_read_enable      : miss fetch request, held until l3_valid
//   l3_out, l3_valid             : fetch response
//   l3_wr_enable/addr/data       : registered one-cycle write-through to L3
//   hit_count, miss_count        : (BLOCK_CACHE_STATS_EN only) statistics
// ---------------------------------------------------------------------------
module block_cache
    import block_cache_pkg::*;
#(
    parameter int PORTS   = 4,
    parameter int ENTRIES = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  BlockPos          addr [PORTS],
    input  logic [PORTS-1:0] read_enable,
    output BlockType         out  [PORTS],
    output logic [PORTS-1:0] valid,
    input  logic             wr_enable,
    input  BlockPos          wr_addr,
    input  BlockType         wr_data,
    output BlockPos          l3_addr,
    output logic             l3_read_enable,
    input  BlockType         l3_out,
    input  logic             l3_valid,
    output logic             l3_wr_enable,
    output BlockPos          l3_wr_addr,
    output BlockType         l3_wr_data
`ifdef BLOCK_CACHE_STATS_EN
    ,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count
`endif
);

    localparam int                 EW    = $clog2(ENTRIES);
    localparam logic [ENTRIES-1:0] E_ONE = ENTRIES'(1);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    BlockPos            r_tag  [ENTRIES];
    BlockType           r_data [ENTRIES];
    logic [ENTRIES-1:0] r_occ;
    logic [EW-1:0]      r_ptr;

    // Per-port registered results
    BlockType           r_out [PORTS];
    logic [PORTS-1:0]   r_valid;

    // Write-through registers
    logic               r_l3_wr_en;
    BlockPos            r_l3_wr_addr;
    BlockType           r_l3_wr_data;

    // Miss FSM
    miss_state_t        r_state, w_state_next;
    BlockPos            r_l3_addr, w_l3_addr_next;
    logic               r_l3_req, w_l3_req_next;
    // A write that hits the in-flight fetch address is remembered here so the
    // fill installs the newer data instead of the stale L3 copy.
    logic               r_ovr_valid, w_ovr_valid_next;
    BlockType           r_ovr_data, w_ovr_data_next;
    logic               w_start_fetch;
    logic               w_fill;

    // ------------------------------------------------------------------
    // Lookup: every port compares against every occupied entry
    // ------------------------------------------------------------------
    logic [PORTS-1:0]   w_hit;
    logic [PORTS-1:0]   w_miss;
    BlockType           w_hit_data [PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_port
            logic [ENTRIES-1:0] w_match;
            BlockType           w_data;

            // Tags are kept unique, so OR-ing the matching data is a mux.
            always_comb begin
                w_match = '0;
                w_data  = '0;
                for (int e = 0; e < ENTRIES; e++) begin
                    w_match[e] = r_occ[e] && (r_tag[e] == addr[gi]);
                    if (w_match[e]) begin
                        w_data = w_data | r_data[e];
                    end
                end
            end

            assign w_hit[gi]      = read_enable[gi] && (|w_match);
            assign w_hit_data[gi] = w_data;
        end
    endgenerate

    assign w_miss = read_enable & ~w_hit;

    // ------------------------------------------------------------------
    // Miss arbitration
    // ------------------------------------------------------------------
    logic [PORTS-1:0] w_grant;
    BlockPos          w_win_addr;

    rr_arbiter #(
        .N (PORTS)
    ) u_rr_arbiter (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .i_req     (w_miss),
        .i_advance (w_start_fetch),
        .o_grant   (w_grant)
    );

    always_comb begin
        w_win_addr = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (w_grant[p]) begin
                w_win_addr = w_win_addr | addr[p];
            end
        end
    end

    // ------------------------------------------------------------------
    // Fill victim selection
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] w_fill_match;
    logic [ENTRIES-1:0] w_wr_match;
    logic [ENTRIES-1:0] w_ptr_oh;
    logic [ENTRIES-1:0] w_free;
    logic [ENTRIES-1:0] w_free_low;
    logic [ENTRIES-1:0] w_victim_oh;
    logic               w_ptr_adv;
    logic               w_wr_hits_fetch;
    BlockType           w_fill_data;

    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            assign w_fill_match[gi] = r_occ[gi] && (r_tag[gi] == r_l3_addr);
            assign w_wr_match[gi]   = r_occ[gi] && (r_tag[gi] == wr_addr);
            assign w_ptr_oh[gi]     = (r_ptr == EW'(gi));
        end
    endgenerate

    assign w_free     = ~r_occ;
    assign w_free_low = w_free & (~w_free + E_ONE);

    // Already present -> overwrite in place; else lowest free; else pointer.
    assign w_victim_oh = (|w_fill_match) ? w_fill_match :
                         (|w_free)       ? w_free_low   : w_ptr_oh;
    assign w_ptr_adv   = w_fill && !(|w_fill_match) && !(|w_free);

    assign w_wr_hits_fetch = wr_enable && (wr_addr == r_l3_addr);
    assign w_fill_data     = w_wr_hits_fetch ? wr_data    :
                             r_ovr_valid     ? r_ovr_data : l3_out;

    // ------------------------------------------------------------------
    // Miss FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= MISS_IDLE;
            r_l3_addr   <= '0;
            r_l3_req    <= 1'b0;
            r_ovr_valid <= 1'b0;
            r_ovr_data  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_l3_addr   <= w_l3_addr_next;
            r_l3_req    <= w_l3_req_next;
            r_ovr_valid <= w_ovr_valid_next;
            r_ovr_data  <= w_ovr_data_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_l3_addr_next   = r_l3_addr;
        w_l3_req_next    = r_l3_req;
        w_ovr_valid_next = r_ovr_valid;
        w_ovr_data_next  = r_ovr_data;
        w_start_fetch    = 1'b0;
        w_fill           = 1'b0;
        case (r_state)
            MISS_IDLE: begin
                // l3_valid here is a stray response and is ignored.
                if (|w_miss) begin
                    w_state_next     = MISS_FETCH;
                    w_l3_addr_next   = w_win_addr;
                    w_l3_req_next    = 1'b1;
                    w_ovr_valid_next = 1'b0;
                    w_start_fetch    = 1'b1;
                end
            end
            MISS_FETCH: begin
                // New misses are not queued; requesters retry once idle.
                if (w_wr_hits_fetch) begin
                    w_ovr_valid_next = 1'b1;
                    w_ovr_data_next  = wr_data;
                end
                if (l3_valid && r_l3_req) begin
                    w_fill        = 1'b1;
                    w_state_next  = MISS_IDLE;
                    w_l3_req_next = 1'b0;
                end
            end
            default: begin
                w_state_next  = MISS_IDLE;
                w_l3_req_next = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Tag/data array (no reset needed: occupancy gates every use)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        for (int e = 0; e < ENTRIES; e++) begin
            // A fill evicting an entry wins over a write to that entry's old
            // address; a write to the fill address is already in w_fill_data.
            if (w_fill && w_victim_oh[e]) begin
                r_tag[e]  <= r_l3_addr;
                r_data[e] <= w_fill_data;
            end else if (wr_enable && w_wr_match[e]) begin
                r_data[e] <= wr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Occupancy, replacement pointer, port outputs, write-through
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_occ        <= '0;
            r_ptr        <= '0;
            r_valid      <= '0;
            r_l3_wr_en   <= 1'b0;
            r_l3_wr_addr <= '0;
            r_l3_wr_data <= '0;
            for (int p = 0; p < PORTS; p++) begin
                r_out[p] <= '0;
            end
        end else begin
            if (w_fill) begin
                r_occ <= r_occ | w_victim_oh;
            end
            if (w_ptr_adv) begin
                r_ptr <= r_ptr + EW'(1);
            end
            // Lookups read the array before this edge's writes land, so a
            // same-cycle write is only visible from the next cycle on.
            r_valid <= w_hit;
            for (int p = 0; p < PORTS; p++) begin
                if (w_hit[p]) begin
                    r_out[p] <= w_hit_data[p];
                end
            end
            r_l3_wr_en <= wr_enable;
            if (wr_enable) begin
                r_l3_wr_addr <= wr_addr;
                r_l3_wr_data <= wr_data;
            end
        end
    end

    assign out            = r_out;
    assign valid          = r_valid;
    assign l3_addr        = r_l3_addr;
    assign l3_read_enable = r_l3_req;
    assign l3_wr_enable   = r_l3_wr_en;
    assign l3_wr_addr     = r_l3_wr_addr;
    assign l3_wr_data     = r_l3_wr_data;

`ifdef BLOCK_CACHE_STATS_EN
    // ------------------------------------------------------------------
    // Statistics: one count per enabled port per cycle
    // ------------------------------------------------------------------
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;
    logic [31:0] w_hit_num;
    logic [31:0] w_miss_num;

    always_comb begin
        w_hit_num  = '0;
        w_miss_num = '0;
        for (int p = 0; p < PORTS; p++) begin
            w_hit_num  = w_hit_num  + 32'(w_hit[p]);
            w_miss_num = w_miss_num + 32'(w_miss[p]);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_hit_count  <= sat_add32(r_hit_count,  w_hit_num);
            r_miss_count <= sat_add32(r_miss_count, w_miss_num);
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_block_cache.sv
// ---------------------------------------------------------------------------
// tb_block_cache
// Directed scenarios with literal expectations, followed by a long random
// run. A behavioural model (arrays + integer arithmetic) predicts every
// registered output; a negedge compare process checks the DUT against it.
// ---------------------------------------------------------------------------
module tb_block_cache;
    import block_cache_pkg::*;

    localparam int P = 4;
    localparam int E = 4;

    logic         clk_in = 1'b0;
    logic         rst_in;
    BlockPos      addr [P];
    logic [P-1:0] read_enable;
    BlockType     out  [P];
    logic [P-1:0] valid;
    logic         wr_enable;
    BlockPos      wr_addr;
    BlockType     wr_data;
    BlockPos      l3_addr;
    logic         l3_read_enable;
    BlockType     l3_out;
    logic         l3_valid;
    logic         l3_wr_enable;
    BlockPos      l3_wr_addr;
    BlockType     l3_wr_data;
`ifdef BLOCK_CACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    block_cache #(
        .PORTS   (P),
        .ENTRIES (E)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .addr           (addr),
        .read_enable    (read_enable),
        .out            (out),
        .valid          (valid),
        .wr_enable      (wr_enable),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .l3_addr        (l3_addr),
        .l3_read_enable (l3_read_enable),
        .l3_out         (l3_out),
        .l3_valid       (l3_valid),
        .l3_wr_enable   (l3_wr_enable),
        .l3_wr_addr     (l3_wr_addr),
        .l3_wr_data     (l3_wr_data)
`ifdef BLOCK_CACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    BlockPos  m_tag  [E];
    BlockType m_data [E];
    bit       m_occ  [E];
    int       m_ptr;
    int       m_last;
    bit       m_busy;
    BlockPos  m_faddr;
    bit       m_ovr;
    BlockType m_ovr_data;
    longint   m_hits;
    longint   m_misses;

    bit       e_valid [P];
    BlockType e_out   [P];
    bit       e_wr_en;
    BlockPos  e_wr_addr;
    BlockType e_wr_data;

    function automatic int m_find(input BlockPos a);
        for (int e = 0; e < E; e++) begin
            if (m_occ[e] && m_tag[e] == a) return e;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int e = 0; e < E; e++) m_occ[e] = 1'b0;
        for (int p = 0; p < P; p++) begin
            e_valid[p] = 1'b0;
            e_out[p]   = '0;
        end
        m_ptr = 0; m_last = P - 1; m_busy = 1'b0; m_faddr = '0;
        m_ovr = 1'b0; m_ovr_data = '0; m_hits = 0; m_misses = 0;
        e_wr_en = 1'b0; e_wr_addr = '0; e_wr_data = '0;
    endtask

    task automatic model_step();
        bit       miss [P];
        int       idx;
        int       win;
        int       c;
        bit       fill;
        BlockPos  f_addr;
        BlockType f_data;
        for (int p = 0; p < P; p++) begin
            idx = m_find(addr[p]);
            miss[p] = 1'b0;
            if (read_enable[p] && idx >= 0) begin
                e_valid[p] = 1'b1;
                e_out[p]   = m_data[idx];
                m_hits++;
            end else begin
                e_valid[p] = 1'b0;
                if (read_enable[p]) begin
                    miss[p] = 1'b1;
                    m_misses++;
                end
            end
        end
        e_wr_en = wr_enable;
        if (wr_enable) begin
            e_wr_addr = wr_addr;
            e_wr_data = wr_data;
        end
        fill = 1'b0; f_addr = '0; f_data = '0;
        if (m_busy) begin
            if (wr_enable && wr_addr == m_faddr) begin
                m_ovr = 1'b1;
                m_ovr_data = wr_data;
            end
            if (l3_valid) begin
                fill = 1'b1;
                f_addr = m_faddr;
                f_data = m_ovr ? m_ovr_data : l3_out;
                m_busy = 1'b0;
            end
        end else begin
            win = -1;
            for (int k = 1; k <= P; k++) begin
                c = (m_last + k) % P;
                if (win < 0 && miss[c]) win = c;
            end
            if (win >= 0) begin
                m_busy = 1'b1; m_faddr = addr[win]; m_last = win; m_ovr = 1'b0;
            end
        end
        if (wr_enable) begin
            idx = m_find(wr_addr);
            if (idx >= 0) m_data[idx] = wr_data;
        end
        if (fill) begin
            idx = m_find(f_addr);
            if (idx < 0) begin
                for (int e = E - 1; e >= 0; e--) if (!m_occ[e]) idx = e;
            end
            if (idx < 0) begin
                idx = m_ptr;
                m_ptr = (m_ptr + 1) % E;
            end
            m_occ[idx] = 1'b1; m_tag[idx] = f_addr; m_data[idx] = f_data;
        end
    endtask

    always @(posedge clk_in) begin
        if (!rst_in) model_reset();
        else         model_step();
    end

    // ------------------------------------------------------------------
    // Compare process: registered outputs are stable at the falling edge
    // ------------------------------------------------------------------
    always @(negedge clk_in) begin
        for (int p = 0; p < P; p++) begin
            chk($sformatf("valid[%0d]", p), 64'(valid[p]), 64'(e_valid[p]));
            chk($sformatf("out[%0d]", p), 64'(out[p]), 64'(e_out[p]));
        end
        chk("l3_read_enable", 64'(l3_read_enable), 64'(m_busy));
        chk("l3_addr", 64'(l3_addr), 64'(m_faddr));
        chk("l3_wr_enable", 64'(l3_wr_enable), 64'(e_wr_en));
        chk("l3_wr_addr", 64'(l3_wr_addr), 64'(e_wr_addr));
        chk("l3_wr_data", 64'(l3_wr_data), 64'(e_wr_data));
`ifdef BLOCK_CACHE_STATS_EN
        chk("hit_count", 64'(hit_count), (m_hits > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(m_hits));
        chk("miss_count", 64'(miss_count), (m_misses > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(m_misses));
`endif
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        read_enable = '0;
        wr_enable   = 1'b0;
        l3_valid    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b1;
    endtask

    // Single-port miss followed by an immediate L3 response.
    task automatic fill_one(input BlockPos a, input BlockType d);
        addr[0] = a;
        read_enable = 4'b0001;
        tick();
        read_enable = '0;
        chk("fill_req", 64'(l3_read_enable), 64'd1);
        chk("fill_addr", 64'(l3_addr), 64'(a));
        l3_out = d;
        l3_valid = 1'b1;
        tick();
        l3_valid = 1'b0;
    endtask

    initial begin
        BlockPos order [$];
        rst_in = 1'b0;
        for (int p = 0; p < P; p++) addr[p] = '0;
        wr_addr = '0; wr_data = '0; l3_out = '0;
        idle_inputs();
        tick();
        tick();
        rst_in = 1'b1;

        // Reset state
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_out0", 64'(out[0]), 64'd0);
        chk("rst_l3_req", 64'(l3_read_enable), 64'd0);
        chk("rst_l3_wr_en", 64'(l3_wr_enable), 64'd0);

        // Miss on 5, response 0xAA three cycles later, then a hit
        addr[0] = 8'd5;
        read_enable = 4'b0001;
        tick();
        chk("a_valid0_miss", 64'(valid[0]), 64'd0);
        chk("a_l3_req", 64'(l3_read_enable), 64'd1);
        chk("a_l3_addr", 64'(l3_addr), 64'd5);
        tick();
        tick();
        chk("a_l3_addr_held", 64'(l3_addr), 64'd5);
        chk("a_l3_req_held", 64'(l3_read_enable), 64'd1);
        l3_out = 32'hAA;
        l3_valid = 1'b1;
        tick();
        l3_valid = 1'b0;
        chk("a_l3_req_drop", 64'(l3_read_enable), 64'd0);
        tick();
        chk("a_valid0_hit", 64'(valid[0]), 64'd1);
        chk("a_out0", 64'(out[0]), 64'hAA);
        read_enable = '0;

        // Four ports missing together are served 1,2,3,4, twice over
        for (int round = 0; round < 2; round++) begin
            do_reset();
            for (int p = 0; p < P; p++) addr[p] = BlockPos'(p + 1);
            read_enable = 4'b1111;
            order.delete();
            for (int cyc = 0; cyc < 40 && order.size() < 4; cyc++) begin
                tick();
                if (l3_read_enable && !l3_valid) begin
                    order.push_back(l3_addr);
                    l3_out = 32'(l3_addr) * 32'h10;
                    l3_valid = 1'b1;
                end else begin
                    l3_valid = 1'b0;
                end
            end
            tick();
            l3_valid = 1'b0;
            read_enable = '0;
            chk("b_fetch_count", 64'(order.size()), 64'd4);
            for (int i = 0; i < order.size(); i++) begin
                chk($sformatf("b_order[%0d]", i), 64'(order[i]), 64'(i + 1));
            end
            tick();
        end

        // Five distinct fills into four entries: 14 evicts 10
        do_reset();
        for (int a = 10; a <= 14; a++) fill_one(BlockPos'(a), BlockType'(a + 'h100));
        addr[0] = 8'd10;
        addr[1] = 8'd11;
        read_enable = 4'b0011;
        tick();
        read_enable = '0;
        chk("c_read10_miss", 64'(valid[0]), 64'd0);
        chk("c_read11_hit", 64'(valid[1]), 64'd1);
        chk("c_out11", 64'(out[1]), 64'h10B);
        l3_valid = 1'b1;
        l3_out = 32'h1234;
        tick();
        l3_valid = 1'b0;

        // Write to the address being fetched supersedes the L3 data
        do_reset();
        addr[0] = 8'd7;
        read_enable = 4'b0001;
        tick();
        read_enable = '0;
        wr_enable = 1'b1;
        wr_addr = 8'd7;
        wr_data = 32'h55;
        tick();
        wr_enable = 1'b0;
        chk("d_wt_en", 64'(l3_wr_enable), 64'd1);
        chk("d_wt_addr", 64'(l3_wr_addr), 64'd7);
        chk("d_wt_data", 64'(l3_wr_data), 64'h55);
        tick();
        chk("d_wt_pulse_end", 64'(l3_wr_enable), 64'd0);
        l3_out = 32'h11;
        l3_valid = 1'b1;
        tick();
        l3_valid = 1'b0;
        read_enable = 4'b0001;
        tick();
        read_enable = '0;
        chk("d_valid0", 64'(valid[0]), 64'd1);
        chk("d_out0", 64'(out[0]), 64'h55);

        // Reset in the middle of a fetch; the late response is ignored
        do_reset();
        addr[0] = 8'd9;
        read_enable = 4'b0001;
        tick();
        read_enable = '0;
        chk("e_req_before", 64'(l3_read_enable), 64'd1);
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        chk("e_req_reset", 64'(l3_read_enable), 64'd0);
        chk("e_valid_reset", 64'(valid), 64'd0);
        l3_out = 32'h77;
        l3_valid = 1'b1;
        tick();
        l3_valid = 1'b0;
        chk("e_req_late", 64'(l3_read_enable), 64'd0);
        read_enable = 4'b0001;
        tick();
        read_enable = '0;
        chk("e_no_fill", 64'(valid[0]), 64'd0);
        l3_valid = 1'b1;
        tick();
        l3_valid = 1'b0;

        // Random traffic against the model
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_in = ($urandom_range(0, 499) != 0);
            read_enable = P'($urandom);
            for (int p = 0; p < P; p++) addr[p] = BlockPos'($urandom_range(0, 7));
            wr_enable = ($urandom_range(0, 3) == 0);
            wr_addr = BlockPos'($urandom_range(0, 7));
            wr_data = $urandom;
            l3_valid = ($urandom_range(0, 2) == 0);
            l3_out = $urandom;
            tick();
        end
        rst_in = 1'b1;
        idle_inputs();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
